// File: rtl/block_pkg.sv
// Shared constants and types for the block sprite fetch path.
package block_pkg;

    localparam int BLK_W      = 23;
    localparam int BLK_H      = 22;
    localparam int BLK_PIXELS = BLK_W * BLK_H;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

    typedef logic [3:0] pixel_idx_t;
    typedef logic [9:0] coord_t;

endpackage

// File: rtl/block_addr_gen.sv
// Combinational rectangle hit test and row-major sprite ROM address for one scan pixel.
// Zero latency; no flow control (one result per presented pixel).
module block_addr_gen
    import block_pkg::coord_t;
#(
    parameter int BLK_W  = block_pkg::BLK_W,
    parameter int BLK_H  = block_pkg::BLK_H,
    parameter int ADDR_W = 9
) (
    input  coord_t              draw_x,
    input  coord_t              draw_y,
    input  coord_t              pos_x,
    input  coord_t              pos_y,
    input  logic                en,
    output logic                hit,
    output logic [ADDR_W-1:0]   addr
);

    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [10:0] lx;
    logic [10:0] ly;
    logic [10:0] row_base;
    logic [10:0] lin;
    logic        in_x;
    logic        in_y;

    always_comb begin
        dx = {1'b0, draw_x};
        dy = {1'b0, draw_y};
        px = {1'b0, pos_x};
        py = {1'b0, pos_y};

        // 11-bit ends so a block hanging off the right/bottom clips instead of wrapping
        x_end = px + 11'(BLK_W);
        y_end = py + 11'(BLK_H);

        in_x = (dx >= px) && (dx < x_end);
        in_y = (dy >= py) && (dy < y_end);
        hit  = en && in_x && in_y;

        lx = dx - px;
        ly = dy - py;
    end

    generate
        if (BLK_W == 23) begin : g_mul23
            assign row_base = (ly << 4) + (ly << 3) - ly;
        end else begin : g_mulc
            assign row_base = 11'(ly * 11'(BLK_W));
        end
    endgenerate

    assign lin  = row_base + lx;
    assign addr = lin[ADDR_W-1:0];

endmodule

// File: rtl/block_pixel_fetch.sv
// Frame-latched block position, per-pixel ROM address, and ROM data realignment to pixel outputs.
// Fixed 3-cycle latency DrawX/DrawY -> pixel_idx/pixel_on, 1 pixel/cycle, no backpressure.
module block_pixel_fetch
    import block_pkg::coord_t;
    import block_pkg::pixel_idx_t;
#(
    parameter int         BLK_W           = block_pkg::BLK_W,
    parameter int         BLK_H           = block_pkg::BLK_H,
    parameter int         ADDR_W          = 9,
    parameter logic [3:0] TRANSPARENT_IDX = block_pkg::TRANSPARENT_IDX
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_start,
    input  coord_t              blk_x,
    input  coord_t              blk_y,
    input  logic                blk_en,
    input  coord_t              DrawX,
    input  coord_t              DrawY,
    output logic [ADDR_W-1:0]   rom_addr,
    input  pixel_idx_t          rom_data,
    output pixel_idx_t          pixel_idx,
    output logic                pixel_on
);

    coord_t              pos_x;
    coord_t              pos_y;
    logic                en;
    logic                hit;
    logic [ADDR_W-1:0]   addr;
    logic                hit1;
    logic                hit2;
    logic                pixel_on_next;

    // Position is only taken at frame start so the sprite never tears mid-frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_x <= '0;
            pos_y <= '0;
            en    <= 1'b0;
        end else if (frame_start) begin
            pos_x <= blk_x;
            pos_y <= blk_y;
            en    <= blk_en;
        end
    end

    block_addr_gen #(
        .BLK_W  (BLK_W),
        .BLK_H  (BLK_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .draw_x (DrawX),
        .draw_y (DrawY),
        .pos_x  (pos_x),
        .pos_y  (pos_y),
        .en     (en),
        .hit    (hit),
        .addr   (addr)
    );

    // hit1/hit2 shadow the address through the ROM's one-cycle read
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            hit1     <= 1'b0;
            hit2     <= 1'b0;
        end else begin
            rom_addr <= hit ? addr : '0;
            hit1     <= hit;
            hit2     <= hit1;
        end
    end

    assign pixel_on_next = hit2 && (rom_data != TRANSPARENT_IDX);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_on  <= 1'b0;
            pixel_idx <= '0;
        end else begin
            pixel_on  <= pixel_on_next;
            pixel_idx <= pixel_on_next ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_block_pixel_fetch.sv
// Directed bench for block_pixel_fetch with a behavioural 1-cycle sprite ROM.
module tb_block_pixel_fetch;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_start;
    logic [9:0] blk_x;
    logic [9:0] blk_y;
    logic       blk_en;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [8:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] pixel_idx;
    logic       pixel_on;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    block_pixel_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .blk_x       (blk_x),
        .blk_y       (blk_y),
        .blk_en      (blk_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_idx   (pixel_idx),
        .pixel_on    (pixel_on)
    );

    // Sprite ROM contents: every 5th word transparent, others 1..15
    function automatic logic [3:0] rom_word(input int a);
        if (a % 5 == 0) return 4'h0;
        return 4'((a % 15) + 1);
    endfunction

    always_ff @(posedge Clk) rom_data <= rom_word(int'(rom_addr));

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_frame(input int x, input int y, input logic e);
        blk_x = 10'(x); blk_y = 10'(y); blk_en = e; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Present one pixel, hold it, check rom_addr after 1 edge and outputs after 3
    task automatic single(input string tag, input int x, input int y,
                          input int exp_addr, input bit exp_hit);
        logic [3:0] w;
        DrawX = 10'(x); DrawY = 10'(y);
        tick();
        check({tag, ".addr"}, int'(rom_addr), exp_addr);
        tick();
        tick();
        w = rom_word(exp_addr);
        check({tag, ".on"},  int'(pixel_on),  (exp_hit && w != 4'h0) ? 1 : 0);
        check({tag, ".idx"}, int'(pixel_idx), (exp_hit && w != 4'h0) ? int'(w) : 0);
    endtask

    int         ea   [0:27];
    bit         eh   [0:27];
    logic [3:0] w;

    initial begin
        Reset_n = 1'b0; frame_start = 1'b0;
        blk_x = '0; blk_y = '0; blk_en = 1'b0;
        DrawX = '0; DrawY = '0;
        #1;
        check("rst.addr", int'(rom_addr), 0);
        check("rst.on",   int'(pixel_on), 0);
        check("rst.idx",  int'(pixel_idx), 0);
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        // Block at (100,50)
        pulse_frame(100, 50, 1'b1);
        single("org",   100, 50, 0,   1'b1);
        single("last",  122, 71, 505, 1'b1);
        single("rmiss", 123, 71, 0,   1'b0);
        single("bmiss", 100, 72, 0,   1'b0);
        single("p1",    101, 50, 1,   1'b1);

        // Row 60 stream, DrawX 98..125: addresses 230..252 for DrawX 100..122
        for (int i = 0; i < 28; i++) begin
            eh[i] = (98 + i >= 100) && (98 + i <= 122);
            ea[i] = eh[i] ? 230 + (98 + i - 100) : 0;
        end
        for (int k = 0; k < 31; k++) begin
            if (k < 28) begin
                DrawX = 10'(98 + k); DrawY = 10'd60;
            end else begin
                DrawX = 10'd0; DrawY = 10'd479;
            end
            tick();
            if (k < 28) check($sformatf("strm.addr%0d", k), int'(rom_addr), ea[k]);
            if (k >= 2 && k - 2 < 28) begin
                w = rom_word(ea[k-2]);
                check($sformatf("strm.on%0d", k - 2), int'(pixel_on),
                      (eh[k-2] && w != 4'h0) ? 1 : 0);
                check($sformatf("strm.idx%0d", k - 2), int'(pixel_idx),
                      (eh[k-2] && w != 4'h0) ? int'(w) : 0);
            end
        end

        // Mid-frame blk_x change without frame_start is ignored
        blk_x = 10'd200;
        single("nolatch", 101, 50, 1, 1'b1);

        // frame_start coincident with an in-flight pixel
        DrawX = 10'd101; DrawY = 10'd50;
        blk_x = 10'd200; blk_y = 10'd50; blk_en = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("flight.old", int'(rom_addr), 1);
        DrawX = 10'd201;
        tick();
        check("flight.new", int'(rom_addr), 1);
        DrawX = 10'd101;
        tick();
        check("flight.oldpos", int'(rom_addr), 0);
        check("flight.on", int'(pixel_on), 1);
        check("flight.idx", int'(pixel_idx), int'(rom_word(1)));

        // Clipped block at (630,100): hits only 630..639, no wrap to column 0
        pulse_frame(630, 100, 1'b1);
        single("clip635", 635, 101, 28, 1'b1);
        single("clip639", 639, 101, 32, 1'b1);
        for (int x = 0; x <= 12; x++) begin
            DrawX = 10'(x); DrawY = 10'd101;
            tick();
            check($sformatf("wrap.addr%0d", x), int'(rom_addr), 0);
        end
        tick(); tick();
        check("wrap.on", int'(pixel_on), 0);

        // Disabled block
        pulse_frame(100, 50, 1'b0);
        single("dis", 101, 50, 0, 1'b0);

        // Async reset while a pixel is being drawn
        pulse_frame(100, 50, 1'b1);
        single("pre", 101, 50, 1, 1'b1);
        Reset_n = 1'b0;
        #1;
        check("arst.on",   int'(pixel_on), 0);
        check("arst.idx",  int'(pixel_idx), 0);
        check("arst.addr", int'(rom_addr), 0);
        tick();
        Reset_n = 1'b1;
        single("postrst", 101, 50, 0, 1'b0);
        pulse_frame(100, 50, 1'b1);
        single("redraw", 101, 50, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_pixel_fetch.md
Name: block_pixel_fetch

Overview:
Per-pixel sprite fetch stage that sits directly upstream of the 23x22 block sprite ROM (4-bit palette index, 1-cycle synchronous read) and directly downstream of the VGA scan counters. It latches the block's screen position once per frame, tests each scan pixel against the block rectangle, and generates the ROM read address. It then re-aligns the ROM data with a hit flag and emits a registered palette index plus an opaque-pixel flag to the colour mapper.

Parameters:
BLK_W, 23, sprite width in pixels
BLK_H, 22, sprite height in pixels
ADDR_W, 9, ROM address width; must satisfy 2^ADDR_W >= BLK_W*BLK_H (506)
TRANSPARENT_IDX, 4'h0, palette index treated as see-through

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
frame_start  in  1  single-cycle pulse at start of vertical blank
blk_x  in  10  block top-left X, sampled only on frame_start
blk_y  in  10  block top-left Y, sampled only on frame_start
blk_en  in  1  block visible, sampled only on frame_start
DrawX  in  10  current scan pixel X (0..639)
DrawY  in  10  current scan pixel Y (0..479)
rom_addr  out  ADDR_W  read address to sprite ROM (registered)
rom_data  in  4  palette index from ROM, valid one cycle after rom_addr
pixel_idx  out  4  palette index for the pixel (registered)
pixel_on  out  1  1 = block pixel present and opaque (registered)

Behaviour:
- Reset (async, Reset_n=0): pos_x, pos_y=0; en=0; rom_addr=0; hit pipeline=0; pixel_idx=0; pixel_on=0. Outputs clear immediately, not at the next edge.
- Frame latch: on a Clk edge with frame_start=1, pos_x<=blk_x, pos_y<=blk_y, en<=blk_en. Otherwise hold. Mid-frame changes on blk_* are ignored, so there is no tearing.
- Hit test for the pixel (DrawX,DrawY) presented in cycle n: hit = en & DrawX>=pos_x & DrawX<pos_x+BLK_W & DrawY>=pos_y & DrawY<pos_y+BLK_H.
  - Sums are computed at 11 bits. A block partly off the right or bottom edge clips and never wraps to column or row 0.
- Address: lx=DrawX-pos_x, ly=DrawY-pos_y; addr = ly*BLK_W + lx, row-major, range 0..505.
  - Use shift/add for ly*23: (ly<<4)+(ly<<3)-ly. No multiplier.
  - Intermediate width is 11 bits, truncated to ADDR_W.
- Pipeline, fixed latency of 3 cycles from DrawX/DrawY to pixel outputs:
  - Edge n+1: rom_addr<=hit ? addr : 0; hit1<=hit.
  - Edge n+2: ROM registers rom_data; hit2<=hit1.
  - Edge n+3: pixel_on<=hit2 & (rom_data!=TRANSPARENT_IDX); pixel_idx<=pixel_on_next ? rom_data : 0.
- Back-to-back pixels stream at 1 pixel/cycle with no bubbles.
- Miss pixels force rom_addr=0. Their ROM data is discarded through hit2=0.
- frame_start coincident with an in-flight pixel: in-flight pixels keep their already-computed hit and address. Only pixels presented after the latch edge use the new position.
- en=0: pixel_on stays 0 for the whole frame. rom_addr stays 0.
- Reset asserted mid-frame: pipeline flushes. After release, en=0 until the next frame_start, so nothing is drawn.

Decomposition:
- Shared package block_pkg:
  - Constants BLK_W, BLK_H, BLK_PIXELS=506, TRANSPARENT_IDX, SCREEN_W=640, SCREEN_H=480.
  - typedef pixel_idx_t (logic [3:0]).
  - typedef coord_t (logic [9:0]).
- One combinational sub-module, block_addr_gen: takes coords and position, returns hit and addr.
- The top level holds the frame latch and the 3-stage alignment pipeline.
- The ROM is instantiated outside the block, at the same level.

Test Plan:
- Reset then frame_start with blk_x=100, blk_y=50, blk_en=1; scan (100,50) -> rom_addr=0 after 1 cycle; pixel_idx equals ROM word 0 after 3 cycles; pixel_on=1 iff that word !=0.
- Scan (122,71) -> rom_addr=505. Scan (123,71) and (100,72) -> pixel_on=0, rom_addr=0.
- Stream DrawX 98..125 on row 60 back-to-back -> rom_addr sequence is 0,0,230..252,0,0,0; pixel_on exactly 23 contiguous cycles minus transparent pixels; latency exactly 3.
- Block at blk_x=630 (clipped) -> hits only for DrawX 630..639; no hit at DrawX 0..12 on the same rows.
- Change blk_x to 200 mid-frame without frame_start -> outputs unchanged. Pulse frame_start -> new position takes effect on the next presented pixel; in-flight pixels are unaffected.
- Assert Reset_n=0 while pixel_on=1 -> pixel_on, pixel_idx, rom_addr read 0 before the next Clk edge. After release, no pixels until frame_start with blk_en=1.
